// File: rtl/arm_ex_pkg.sv
// Shared definitions for the execute stage: ALU commands, shift types,
// status-flag bit positions and the multiplier FSM states.
package arm_ex_pkg;

   localparam int MUL_BITS = 32;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MUL = 4'b1010;

   localparam logic [1:0] SHIFT_LSL = 2'b00;
   localparam logic [1:0] SHIFT_LSR = 2'b01;
   localparam logic [1:0] SHIFT_ASR = 2'b10;
   localparam logic [1:0] SHIFT_ROR = 2'b11;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

   // A rotate by zero must return x unchanged; the left shift by 32 yields 0.
   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
      ror32 = (x >> r) | (x << (6'd32 - {1'b0, r}));
   endfunction

endpackage

// File: rtl/ex_mul_unit.sv
// Iterative shift-and-add 32x32 multiplier (low word of the product).
// Optional MUL_EARLY_TERM_EN leaves BUSY once the remaining multiplier bits are zero.
module ex_mul_unit
   import arm_ex_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [31:0] multiplicand_i,
   input  logic [31:0] multiplier_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] product_o
);

   localparam int CNT_W = $clog2(MUL_BITS);

   mul_state_t          state_q, state_d;
   logic [MUL_BITS-1:0] mcand_q, mcand_d;
   logic [MUL_BITS-1:0] mplier_q, mplier_d;
   logic [MUL_BITS-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                lastIter;

`ifdef MUL_EARLY_TERM_EN
   assign lastIter = (count_q == '0) || ((mplier_q >> 1) == '0);
`else
   assign lastIter = (count_q == '0);
`endif

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      count_d  = count_q;
      busy_o   = 1'b0;
      done_o   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               busy_o   = 1'b1;
               mcand_d  = multiplicand_i;
               mplier_d = multiplier_i;
               acc_d    = '0;
               count_d  = CNT_W'(MUL_BITS - 1);
               state_d  = BUSY;
            end
         end
         BUSY: begin
            busy_o = 1'b1;
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (lastIter) begin
               state_d = DONE;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
      end
   end

   assign product_o = acc_q;

endmodule

// File: rtl/ex_stage_mul.sv
// Execute stage: val2 generation, ALU, branch-target adder, NZCV register and
// the iterative multiplier (early termination under MUL_EARLY_TERM_EN).
module ex_stage_mul
   import arm_ex_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  exec_cmd_in,
   input  logic        imm_in,
   input  logic        mem_r_en_in,
   input  logic        mem_w_en_in,
   input  logic        s_in,
   input  logic        b_in,
   input  logic [11:0] shift_operand_in,
   input  logic [23:0] signed_immed_24_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] val_rn_in,
   input  logic [31:0] val_rm_in,
   output logic [31:0] alu_result,
   output logic [31:0] br_addr,
   output logic        branch_taken,
   output logic [3:0]  status,
   output logic        stall,
   output logic        mul_done
);

   logic [3:0]  status_q, status_d;
   logic [31:0] val2;
   logic [4:0]  shAmt;
   logic [31:0] addB;
   logic        addCin;
   logic        isArith;
   logic [32:0] sum33;
   logic [31:0] aluRes;
   logic        isMul;
   logic        mulBusy;
   logic        mulDone;
   logic [31:0] mulProduct;

   assign shAmt = shift_operand_in[11:7];
   assign isMul = (exec_cmd_in == CMD_MUL);

   always_comb begin
      val2 = '0;
      if (imm_in) begin
         val2 = ror32({24'b0, shift_operand_in[7:0]}, {shift_operand_in[11:8], 1'b0});
      end else if (mem_r_en_in || mem_w_en_in) begin
         val2 = {20'b0, shift_operand_in};
      end else begin
         case (shift_operand_in[6:5])
            SHIFT_LSL: val2 = val_rm_in << shAmt;
            SHIFT_LSR: val2 = val_rm_in >> shAmt;
            SHIFT_ASR: val2 = 32'($signed(val_rm_in) >>> shAmt);
            default:   val2 = ror32(val_rm_in, shAmt);
         endcase
      end
   end

   // Subtraction is rn + ~val2 + cin, so carry-out is directly NOT borrow.
   always_comb begin
      addB    = '0;
      addCin  = 1'b0;
      isArith = 1'b0;
      case (exec_cmd_in)
         CMD_ADD: begin isArith = 1'b1; addB = val2;  addCin = 1'b0;             end
         CMD_ADC: begin isArith = 1'b1; addB = val2;  addCin = status_q[FLAG_C]; end
         CMD_SUB: begin isArith = 1'b1; addB = ~val2; addCin = 1'b1;             end
         CMD_SBC: begin isArith = 1'b1; addB = ~val2; addCin = status_q[FLAG_C]; end
         default: ;
      endcase
   end

   assign sum33 = {1'b0, val_rn_in} + {1'b0, addB} + {32'b0, addCin};

   always_comb begin
      aluRes = '0;
      case (exec_cmd_in)
         CMD_MOV: aluRes = val2;
         CMD_MVN: aluRes = ~val2;
         CMD_AND: aluRes = val_rn_in & val2;
         CMD_ORR: aluRes = val_rn_in | val2;
         CMD_EOR: aluRes = val_rn_in ^ val2;
         CMD_MUL: aluRes = mulProduct;
         default: aluRes = isArith ? sum33[31:0] : '0;
      endcase
   end

   always_comb begin
      status_d         = status_q;
      status_d[FLAG_N] = aluRes[31];
      status_d[FLAG_Z] = (aluRes == '0);
      if (isArith) begin
         status_d[FLAG_C] = sum33[32];
         status_d[FLAG_V] = (val_rn_in[31] == addB[31]) && (sum33[31] != val_rn_in[31]);
      end
   end

   // A MUL only retires its flags in the DONE cycle; everything else retires each cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_q <= '0;
      end else if (s_in && (!isMul || mulDone)) begin
         status_q <= status_d;
      end
   end

   ex_mul_unit u_mul (
      .clk            (clk),
      .rst            (rst),
      .start_i        (isMul && rst),
      .multiplicand_i (val_rm_in),
      .multiplier_i   (val_rn_in),
      .busy_o         (mulBusy),
      .done_o         (mulDone),
      .product_o      (mulProduct)
   );

   assign alu_result   = aluRes;
   assign br_addr      = pc_in + {{6{signed_immed_24_in[23]}}, signed_immed_24_in, 2'b00};
   assign branch_taken = b_in;
   assign status       = status_q;
   assign stall        = mulBusy;
   assign mul_done     = mulDone;

endmodule
